// File: rtl/mem_responder.sv
// Slave-side memory responder for the CPU mem_read/mem_write/mem_resp handshake.
// Word-organised array with byte-enable writes, programmable latency and protocol-error flagging.
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   accept;
  logic                   err_set;
  logic                   tamper;

  logic                   lat_write;
  logic [ADDR_BITS-1:0]   lat_index;
  logic [1:0]             lat_be;
  logic [15:0]            lat_wdata;

  logic                   req;
  logic [ADDR_BITS-1:0]   req_index;
  logic                   rd_write;
  logic [ADDR_BITS-1:0]   rd_index;
  logic [15:0]            rdata_nxt;
  logic                   addr_unused;

  logic [15:0]            mem [DEPTH];

  assign req         = mem_read | mem_write;
  assign req_index   = mem_address[ADDR_BITS:1];
  assign addr_unused = ^mem_address;

  // Any deviation from the accepted request while it is pending is an initiator error.
  assign tamper = (mem_write != lat_write) ||
                  (req_index != lat_index) ||
                  (lat_write && (mem_wdata != lat_wdata));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          err_set = mem_read & mem_write;
          if (LATENCY <= 1) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
        end else begin
          err_set = (mem_read & mem_write) | tamper;
          if (cnt == 4'd0) begin
            state_nxt = RESP;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Read data is captured on the edge that enters RESP; for LATENCY=1 that is
  // the accepting edge, so the live request is used instead of the latched one.
  always_comb begin
    rd_write  = accept ? mem_write : lat_write;
    rd_index  = accept ? req_index : lat_index;
    rdata_nxt = 16'h0000;
    if ((state_nxt == RESP) && !rd_write) begin
      rdata_nxt = mem[rd_index];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      proto_err <= 1'b0;
      mem_rdata <= 16'h0000;
      lat_write <= 1'b0;
      lat_index <= '0;
      lat_be    <= 2'b00;
      lat_wdata <= 16'h0000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_rdata <= rdata_nxt;
      if (err_set) begin
        proto_err <= 1'b1;
      end
      if (accept) begin
        lat_write <= mem_write;
        lat_index <= req_index;
        lat_be    <= mem_byte_enable;
        lat_wdata <= mem_wdata;
      end
    end
  end

  // NOTE: the array is deliberately not reset; reset only aborts the pending transaction.
  always_ff @(posedge clk) begin
    if ((state == RESP) && lat_write) begin
      if (lat_be[0]) begin
        mem[lat_index][7:0] <= lat_wdata[7:0];
      end
      if (lat_be[1]) begin
        mem[lat_index][15:8] <= lat_wdata[15:8];
      end
    end
  end

  assign mem_resp = (state == RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// against a word-array reference model; second instance covers LATENCY=1.
module tb_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;

  logic        b_read, b_write;
  logic [1:0]  b_be;
  logic [15:0] b_address, b_wdata;
  logic        b_resp;
  logic [15:0] b_rdata;
  logic        b_err;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] model [256];
  bit          exp_err  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .proto_err       (proto_err)
  );

  mem_responder #(.LATENCY(1), .ADDR_BITS(8)) u_dut_lat1 (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (b_read),
    .mem_write       (b_write),
    .mem_byte_enable (b_be),
    .mem_address     (b_address),
    .mem_wdata       (b_wdata),
    .mem_resp        (b_resp),
    .mem_rdata       (b_rdata),
    .proto_err       (b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[8:1]);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  // One complete transaction on the LATENCY=4 instance, called and returning at a negedge.
  task automatic txn(input string tag, input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [1:0] be, input logic [15:0] wd);
    int          k;
    bit          got;
    logic [15:0] exp;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    if (rd && wr) exp_err = 1'b1;
    exp = model[widx(addr)];
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (mem_resp) got = 1'b1;
      else check({tag, "/rdata_pre"}, mem_rdata, 16'h0);
    end
    check({tag, "/latency"}, k, LAT);
    if (rd && !wr) check({tag, "/rdata"}, mem_rdata, exp);
    if (wr) model[widx(addr)] = merge(model[widx(addr)], wd, be);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check({tag, "/resp_post"}, mem_resp, 1'b0);
    check({tag, "/rdata_post"}, mem_rdata, 16'h0);
    check({tag, "/proto_err"}, proto_err, exp_err);
  endtask

  // Request dropped after two BUSY cycles: nothing may complete.
  task automatic abort_txn(input string tag, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wd);
    bit seen;
    mem_read        = !wr;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = 2'b11;
    mem_wdata       = wd;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    seen      = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (mem_resp) seen = 1'b1;
    end
    check({tag, "/no_resp"}, seen, 1'b0);
  endtask

  initial begin
    int          t0, t1, k;
    bit          got;
    logic [15:0] a;
    int          idx;

    reset           = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_address     = 16'h0;
    mem_wdata       = 16'h0;
    b_read          = 1'b0;
    b_write         = 1'b0;
    b_be            = 2'b00;
    b_address       = 16'h0;
    b_wdata         = 16'h0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0;

    repeat (2) @(negedge clk);
    check("reset/resp", mem_resp, 1'b0);
    check("reset/rdata", mem_rdata, 16'h0);
    check("reset/proto_err", proto_err, 1'b0);
    check("reset/lat1_resp", b_resp, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read with exact latency.
    txn("wr_beef", 0, 1, 16'h0010, 2'b11, 16'hBEEF);
    txn("rd_beef", 1, 0, 16'h0010, 2'b00, 16'h0);
    check("beef_model", model[8], 16'hBEEF);

    // Byte merge.
    txn("wr_1234", 0, 1, 16'h0020, 2'b11, 16'h1234);
    txn("wr_hi",   0, 1, 16'h0020, 2'b10, 16'hAB00);
    txn("rd_ab34", 1, 0, 16'h0020, 2'b00, 16'h0);
    txn("wr_lo",   0, 1, 16'h0020, 2'b01, 16'h00CD);
    txn("rd_abcd", 1, 0, 16'h0020, 2'b00, 16'h0);
    txn("wr_be0",  0, 1, 16'h0020, 2'b00, 16'hFFFF);
    txn("rd_be0",  1, 0, 16'h0020, 2'b00, 16'h0);

    // Address wrap.
    txn("wr_wrap", 0, 1, 16'h0202, 2'b11, 16'h5555);
    txn("rd_wrap", 1, 0, 16'h0002, 2'b00, 16'h0);

    // Aborts: read then write; the write must not land.
    abort_txn("abort_rd", 1'b0, 16'h0010, 16'h0);
    txn("rd_after_abort", 1, 0, 16'h0010, 2'b00, 16'h0);
    abort_txn("abort_wr", 1'b1, 16'h0010, 16'h9999);
    txn("rd_after_wabort", 1, 0, 16'h0010, 2'b00, 16'h0);

    // Back-to-back reads with mem_read held across the resp edge.
    mem_read    = 1'b1;
    mem_address = 16'h0020;
    t0 = -100;
    t1 = -1000;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_resp) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
        check("b2b/rdata", mem_rdata, model[16]);
      end
    end
    mem_read = 1'b0;
    @(negedge clk);
    check("b2b/gap", t1 - t0, LAT + 1);

    // Randomized traffic over a small word pool with random upper address bits.
    for (int i = 0; i < 16; i++)
      txn("rnd_init", 0, 1, 16'(16'h0080 + 2 * i), 2'b11, 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      idx = 16'h40 + $urandom_range(0, 15);
      a   = {7'($urandom), 8'(idx), 1'($urandom)};
      if ($urandom_range(0, 1) == 1)
        txn("rnd_wr", 0, 1, a, 2'($urandom), 16'($urandom));
      else
        txn("rnd_rd", 1, 0, a, 2'($urandom), 16'($urandom));
    end

    // LATENCY=1 instance: single write, then held reads every 2 cycles.
    b_write   = 1'b1;
    b_address = 16'h0044;
    b_be      = 2'b11;
    b_wdata   = 16'hC3A5;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (b_resp) got = 1'b1;
    end
    check("lat1/wr_latency", k, 1);
    b_write = 1'b0;
    @(negedge clk);
    b_read = 1'b1;
    t0 = -100;
    t1 = -1000;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (b_resp) begin
        if (t0 < 0) t0 = cyc;
        else t1 = cyc;
        check("lat1/rdata", b_rdata, 16'hC3A5);
      end
    end
    b_read = 1'b0;
    @(negedge clk);
    check("lat1/gap", t1 - t0, 2);
    check("lat1/proto_err", b_err, 1'b0);

    // Address changed while BUSY: error flagged, original word returned.
    check("tamper/pre_err", proto_err, 1'b0);
    mem_read    = 1'b1;
    mem_address = 16'h0020;
    @(posedge clk);
    @(negedge clk);
    mem_address = 16'h0010;
    exp_err     = 1'b1;
    k   = 1;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (mem_resp) got = 1'b1;
    end
    check("tamper/latency", k, LAT);
    check("tamper/rdata", mem_rdata, model[widx(16'h0020)]);
    check("tamper/proto_err", proto_err, 1'b1);
    mem_read = 1'b0;
    @(negedge clk);

    // Async reset mid-BUSY of a write over zero.
    txn("wr_zero", 0, 1, 16'h0060, 2'b11, 16'h0000);
    mem_write       = 1'b1;
    mem_address     = 16'h0060;
    mem_byte_enable = 2'b11;
    mem_wdata       = 16'hFFFF;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_busy/resp", mem_resp, 1'b0);
    check("rst_busy/proto_err", proto_err, 1'b0);
    exp_err   = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn("rd_after_rst", 1, 0, 16'h0060, 2'b00, 16'h0);

    // Async reset while a read response is on the bus.
    mem_read    = 1'b1;
    mem_address = 16'h0010;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_resp) got = 1'b1;
    end
    check("rst_resp/seen", got, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("rst_resp/resp", mem_resp, 1'b0);
    check("rst_resp/rdata", mem_rdata, 16'h0);
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Read and write both high: write wins, error flagged.
    txn("both_hi", 1, 1, 16'h0030, 2'b11, 16'h0F0F);
    txn("rd_both", 1, 0, 16'h0030, 2'b00, 16'h0);
    check("both_model", model[24], 16'h0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Slave-side model of the CPU memory interface; it answers the mem_read/mem_write/mem_resp handshake that the CPU drives on its instruction and data ports.
- Backed by a word-organised register array with byte-enable writes and a programmable response latency.
- One instance serves an i_mem port, or a d_mem port, in integration and CPU-level benches.
- Also flags protocol violations by the initiator.

Parameters:
- LATENCY, 4, cycles from request acceptance to the mem_resp cycle; legal range 1..15.
- ADDR_BITS, 8, number of word-address bits; array depth is 2**ADDR_BITS 16-bit words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_read  input  1  read request; held by the initiator until mem_resp.
- mem_write  input  1  write request; held by the initiator until mem_resp.
- mem_byte_enable  input  2  write mask; bit1 is the high byte, bit0 the low byte; ignored for reads.
- mem_address  input  16  byte address; bit0 ignored; word index is mem_address[ADDR_BITS:1], higher bits are ignored (address wraps modulo depth).
- mem_wdata  input  16  write data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  16  read data; valid only while mem_resp=1, otherwise 16'h0000.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; mem_resp=0; mem_rdata=0; proto_err=0; latency counter=0.
  - Array contents are not reset.
  - Reset mid-transaction aborts the transaction; no write occurs.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If mem_read or mem_write is sampled high at the edge, latch the request: kind, word index, byte_enable, wdata.
  - If LATENCY=1, go to RESP. Otherwise load counter=LATENCY-2 and go to BUSY.
- BUSY:
  - If mem_read=0 and mem_write=0, abort: go to IDLE, no resp, no write.
  - Else if counter=0, go to RESP; otherwise decrement the counter.
- RESP:
  - mem_resp=1 for exactly this one cycle; then go to IDLE.
  - Read: mem_rdata=array[latched index], sampled when entering RESP. The value includes any write committed at or before that edge.
  - Write: commit at the edge that ends RESP. Bytes with enable=1 are replaced; other bytes are kept. byte_enable=2'b00 still produces a resp but changes nothing.
  - RESP is always committed; deassertion during RESP is ignored.
- Latency: request sampled at edge t gives mem_resp high in cycle t+LATENCY.
- Back-to-back: a request still high in the cycle after RESP is a new request and is accepted from IDLE. Maximum throughput is one transaction per LATENCY+1 cycles.
- Protocol errors; proto_err is set and stays set until reset:
  - mem_read and mem_write both high when sampled. The write takes priority and is executed.
  - In BUSY, the address, kind or wdata differs from the latched value. The latched values are used and the transaction continues.
- Latched values are never updated while a transaction is pending.

Test Plan:
- LATENCY=4. Write 16'hBEEF to addr 16'h0010, be=2'b11, then read 16'h0010. Required: each resp arrives exactly 4 cycles after its request sample, and rdata=16'hBEEF in the resp cycle. rdata must be 0 in the cycle before and the cycle after resp.
- Byte merge. Word 0x0020 holds 16'h1234.
  - Write 16'hAB00 with be=2'b10, then read: rdata=16'hAB34.
  - Write 16'h00CD with be=2'b01, then read: rdata=16'hABCD.
  - be=2'b00 write: resp asserted, data unchanged.
- Wrap and abort:
  - With ADDR_BITS=8, write 16'h5555 to 16'h0202, then read 16'h0002: rdata=16'h5555.
  - Drop mem_read after 2 BUSY cycles: no resp, FSM back in IDLE, and the next read completes normally.
- Back-to-back reads with mem_read held high across the resp edge: two resps exactly 5 cycles apart. Repeat with LATENCY=1: resp every 2 cycles.
- Protocol errors:
  - mem_read=mem_write=1 with wdata=16'h0F0F to 16'h0030: proto_err=1, and a later read returns 16'h0F0F.
  - Address changed while BUSY: proto_err stays 1, and the original address is used.
- Reset asserted asynchronously mid-BUSY of a write of 16'hFFFF over 16'h0000: mem_resp and proto_err drop immediately, and a later read returns 16'h0000.
